wave_gen: RTL and testbench
===========================

Name: wave_gen

Overview:
- Programmable pulse-burst generator.
- LOAD captures a 4-bit pulse width N from W_PUL_N.
- A rising edge on the slow, level-style START input launches a burst of PULSE_CNT pulses on OUT, each N clocks high, separated by GAP_W clocks low.
- RDY flags idle and readiness for a new LOAD or START; the block sits between a control/sequencer block and the downstream pulse consumer.

Parameters:
- PULSE_CNT, default 3: pulses per burst, range 1..15.
- GAP_W, default 2: low clocks between consecutive pulses, range 1..15.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  burst trigger; only its rising edge is significant; may stay high many cycles.
- LOAD  in  1  level strobe; when high on an edge in IDLE, W_PUL_N is latched.
- W_PUL_N  in  4  pulse width in clocks (N).
- OUT  out  1  generated waveform, registered.
- RDY  out  1  high when IDLE, registered.

Behaviour:
- Reset (RST high on an edge):
  - OUT=0, RDY=1, width register WREG=0, start_prev=0.
  - State becomes IDLE and all counters clear.
  - Reset mid-burst aborts immediately.
- Edge detect: start_prev is registered START. start_rise = START & ~start_prev, evaluated combinationally in the current cycle.
- States: IDLE, HIGH, GAP.
- IDLE:
  - LOAD=1 → WREG <= W_PUL_N.
  - start_rise with effective width W≠0 → HIGH, OUT<=1, RDY<=0, width counter <= W-1, pulse counter <= PULSE_CNT-1.
  - W = W_PUL_N if LOAD is simultaneously high, else WREG. Simultaneous LOAD and start uses the new value.
  - start_rise with W=0 → ignored; stay IDLE, RDY=1, OUT=0.
- HIGH:
  - OUT=1. The width counter decrements each clock.
  - When the width counter is 0:
    - If the pulse counter is 0 → IDLE, OUT<=0, RDY<=1.
    - Otherwise → GAP, OUT<=0, gap counter <= GAP_W-1, pulse counter decrements.
  - Result: OUT high exactly N consecutive clocks per pulse.
- GAP:
  - OUT=0. The gap counter decrements.
  - When the gap counter is 0 → HIGH, OUT<=1, width counter <= WREG-1.
  - Result: exactly GAP_W low clocks between pulses. No trailing gap after the last pulse.
- Latency: OUT rises one clock after the edge on which start_rise is sampled. RDY falls on that same edge.
- Busy duration: PULSE_CNT*N + (PULSE_CNT-1)*GAP_W clocks with RDY=0.
- LOAD while busy: ignored; WREG unchanged; the burst keeps its width.
- START rising edge while busy: ignored, not queued.
- A START held high through burst end does not retrigger; a new low→high transition is required.
- START falling edge: no effect.
- N=15 is the maximum width. The counters are 4 bits wide and do not wrap.

Decomposition:
- Shared package wave_gen_pkg:
  - state enum (IDLE, HIGH, GAP)
  - width constant CNT_W=4
  - default PULSE_CNT and GAP_W values
- Optional sub-module: rise_detect (registered previous value plus AND), reusable elsewhere.
- The FSM and counters stay in wave_gen.

Test Plan:
- Reset → OUT=0, RDY=1; a START rise before any LOAD (WREG=0) → no pulses, RDY stays 1.
- LOAD with W_PUL_N=5, then START rise → OUT pattern 5 high, 2 low, 5 high, 2 low, 5 high. RDY=0 for 19 clocks, then 1; OUT rises 1 clock after the start edge.
- LOAD and START rise on the same clock with W_PUL_N=1 → pulses 1 high/2 low ×3 using width 1; busy 7 clocks.
- During a burst with N=4, assert LOAD with W_PUL_N=9 and a second START rise → burst finishes with width 4, no second burst, WREG still 4. A following START rise after RDY=1 gives width-4 pulses.
- W_PUL_N=15 burst → three pulses of exactly 15 clocks; busy 49 clocks; no counter wrap.
- RST asserted mid-HIGH → next clock OUT=0, RDY=1, WREG=0. A subsequent START rise produces no pulses until a LOAD.

Source files
------------

// File: rtl/wave_gen_pkg.sv
// Shared types and constants for the pulse-burst generator.
package wave_gen_pkg;

  // Counter width; also the width of the pulse-width input.
  localparam int unsigned CNT_W = 4;

  // Default burst shape.
  localparam int unsigned PulseCntDefault = 3;
  localparam int unsigned GapWDefault     = 2;

  typedef enum logic [1:0] {
    StIdle,
    StHigh,
    StGap
  } state_e;

endpackage

// File: rtl/wave_gen_rise_detect.sv
// Rising-edge detector: registered previous value ANDed with the live input.
module wave_gen_rise_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o
);

  logic prev_d, prev_q;

  // Next value of the delayed copy is simply the current input.
  always_comb begin
    prev_d = d_i;
  end

  // Delayed copy of the input, cleared by synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/wave_gen.sv
// Programmable pulse-burst generator: a START rising edge emits PULSE_CNT
// pulses of WREG clocks high, separated by GAP_W clocks low.
module wave_gen
  import wave_gen_pkg::*;
#(
  parameter int unsigned PULSE_CNT = PulseCntDefault,
  parameter int unsigned GAP_W     = GapWDefault
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             LOAD,
  input  logic [CNT_W-1:0] W_PUL_N,
  output logic             OUT,
  output logic             RDY
);

  localparam logic [CNT_W-1:0] PcInit  = CNT_W'(PULSE_CNT - 1);
  localparam logic [CNT_W-1:0] GapInit = CNT_W'(GAP_W - 1);

  state_e           state_d, state_q;
  logic [CNT_W-1:0] wcnt_d, wcnt_q;  // remaining high clocks minus one
  logic [CNT_W-1:0] pcnt_d, pcnt_q;  // pulses still to come after the current one
  logic [CNT_W-1:0] gcnt_d, gcnt_q;  // remaining gap clocks minus one
  logic [CNT_W-1:0] wreg_d, wreg_q;
  logic [CNT_W-1:0] eff_w;
  logic             out_d, out_q;
  logic             rdy_d, rdy_q;
  logic             start_rise;

  wave_gen_rise_detect u_rise_detect (
    .clk_i  (CLK),
    .rst_i  (RST),
    .d_i    (START),
    .rise_o (start_rise)
  );

  // State, counters and width register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      wcnt_q  <= '0;
      pcnt_q  <= '0;
      gcnt_q  <= '0;
      wreg_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      pcnt_q  <= pcnt_d;
      gcnt_q  <= gcnt_d;
      wreg_q  <= wreg_d;
    end
  end

  // Next-state and counter update; LOAD and START only matter in idle.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    pcnt_d  = pcnt_q;
    gcnt_d  = gcnt_q;
    wreg_d  = wreg_q;
    // A simultaneous LOAD supplies the width for the burst it launches.
    eff_w   = LOAD ? W_PUL_N : wreg_q;
    unique case (state_q)
      StIdle: begin
        if (LOAD) begin
          wreg_d = W_PUL_N;
        end
        if (start_rise && (eff_w != '0)) begin
          state_d = StHigh;
          wcnt_d  = eff_w - CNT_W'(1);
          pcnt_d  = PcInit;
        end
      end
      StHigh: begin
        if (wcnt_q == '0) begin
          if (pcnt_q == '0) begin
            state_d = StIdle;
          end else begin
            state_d = StGap;
            gcnt_d  = GapInit;
            pcnt_d  = pcnt_q - CNT_W'(1);
          end
        end else begin
          wcnt_d = wcnt_q - CNT_W'(1);
        end
      end
      StGap: begin
        if (gcnt_q == '0) begin
          state_d = StHigh;
          wcnt_d  = wreg_q - CNT_W'(1);
        end else begin
          gcnt_d = gcnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registers line up with it.
  always_comb begin
    out_d = (state_d == StHigh);
    rdy_d = (state_d == StIdle);
  end

  // Registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_q <= 1'b0;
      rdy_q <= 1'b1;
    end else begin
      out_q <= out_d;
      rdy_q <= rdy_d;
    end
  end

  assign OUT = out_q;
  assign RDY = rdy_q;

endmodule

// File: tb/tb_wave_gen.sv
// Bench for wave_gen: directed steps plus random stimulus, checked each cycle
// against a queue-based model of the expected OUT waveform.
module tb_wave_gen;

  localparam int PC = 3;
  localparam int GW = 2;

  logic       CLK = 1'b0;
  logic       RST;
  logic       START;
  logic       LOAD;
  logic [3:0] W_PUL_N;
  logic       OUT;
  logic       RDY;

  always #5 CLK = ~CLK;

  wave_gen #(
    .PULSE_CNT (PC),
    .GAP_W     (GW)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .START   (START),
    .LOAD    (LOAD),
    .W_PUL_N (W_PUL_N),
    .OUT     (OUT),
    .RDY     (RDY)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Model: width register, previous START, and the remaining OUT samples of
  // the burst in flight (front entry is what OUT shows right now).
  int m_wreg = 0;
  bit m_prev = 1'b0;
  bit m_q[$];

  task automatic check(input string tag);
    bit exp_out;
    bit exp_rdy;
    exp_out = (m_q.size() != 0) ? m_q[0] : 1'b0;
    exp_rdy = (m_q.size() == 0);
    n_assert++;
    assert (OUT === exp_out) else begin
      n_fail++;
      $error("FAIL %s OUT observed=%b expected=%b", tag, OUT, exp_out);
    end
    n_assert++;
    assert (RDY === exp_rdy) else begin
      n_fail++;
      $error("FAIL %s RDY observed=%b expected=%b", tag, RDY, exp_rdy);
    end
  endtask

  // Apply one cycle of inputs, advance the model across the edge, then check.
  task automatic step(input bit rst, input bit st, input bit ld, input int w,
                      input string tag);
    int eff;
    RST     = rst;
    START   = st;
    LOAD    = ld;
    W_PUL_N = 4'(w);
    @(posedge CLK);
    if (rst) begin
      m_wreg = 0;
      m_prev = 1'b0;
      m_q.delete();
    end else begin
      if (m_q.size() != 0) begin
        void'(m_q.pop_front());
      end else begin
        eff = ld ? w : m_wreg;
        if (ld) m_wreg = w;
        if (st && !m_prev && eff != 0) begin
          for (int p = 0; p < PC; p++) begin
            for (int k = 0; k < eff; k++) m_q.push_back(1'b1);
            if (p != PC - 1) for (int k = 0; k < GW; k++) m_q.push_back(1'b0);
          end
        end
      end
      m_prev = st;
    end
    #1;
    check(tag);
  endtask

  task automatic idle_cycles(input int n, input bit st, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, st, 1'b0, 0, tag);
  endtask

  int busy;

  initial begin
    RST = 1'b1; START = 1'b0; LOAD = 1'b0; W_PUL_N = '0;

    // Reset, then a START rise with WREG=0 must do nothing.
    step(1'b1, 1'b0, 1'b0, 0, "reset");
    step(1'b1, 1'b0, 1'b0, 0, "reset2");
    idle_cycles(2, 1'b0, "post_reset");
    idle_cycles(4, 1'b1, "start_no_width");
    idle_cycles(2, 1'b0, "start_no_width_low");

    // Width 5 burst; also count busy cycles explicitly.
    step(1'b0, 1'b0, 1'b1, 5, "load5");
    step(1'b0, 1'b1, 1'b0, 0, "start5");
    busy = 0;
    for (int i = 0; i < 30; i++) begin
      if (RDY === 1'b0) busy++;
      step(1'b0, 1'b0, 1'b0, 0, "burst5");
    end
    n_assert++;
    assert (busy === 19) else begin
      n_fail++;
      $error("FAIL busy5 cycles observed=%0d expected=%0d", busy, 19);
    end

    // LOAD and START together with width 1.
    step(1'b0, 1'b1, 1'b1, 1, "load_start1");
    idle_cycles(10, 1'b0, "burst1");

    // Width 4 burst, with LOAD 9 and a second START rise while busy.
    step(1'b0, 1'b0, 1'b1, 4, "load4");
    step(1'b0, 1'b1, 1'b0, 0, "start4");
    idle_cycles(2, 1'b1, "held4");
    step(1'b0, 1'b0, 1'b1, 9, "busy_load9");
    step(1'b0, 1'b0, 1'b0, 0, "busy_low");
    step(1'b0, 1'b1, 1'b0, 0, "busy_start");
    idle_cycles(25, 1'b1, "held_through_end");
    idle_cycles(2, 1'b0, "release");
    step(1'b0, 1'b1, 1'b0, 0, "restart4");
    idle_cycles(22, 1'b0, "burst4b");

    // Maximum width.
    step(1'b0, 1'b0, 1'b1, 15, "load15");
    step(1'b0, 1'b1, 1'b0, 0, "start15");
    idle_cycles(55, 1'b0, "burst15");

    // Reset mid-HIGH, then START without LOAD yields nothing.
    step(1'b0, 1'b0, 1'b1, 6, "load6");
    step(1'b0, 1'b1, 1'b0, 0, "start6");
    idle_cycles(3, 1'b0, "high6");
    step(1'b1, 1'b0, 1'b0, 0, "mid_reset");
    idle_cycles(2, 1'b0, "after_reset");
    idle_cycles(3, 1'b1, "start_after_reset");
    idle_cycles(2, 1'b0, "after_reset_low");

    // Random stimulus: START toggles occasionally, LOAD sparse, rare resets.
    begin
      bit st;
      st = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 5) == 0) st = ~st;
        step(($urandom_range(0, 299) == 0), st, ($urandom_range(0, 7) == 0),
             int'($urandom_range(0, 15)), "random");
      end
    end
    idle_cycles(60, 1'b0, "drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
